// File: rtl/buzzer_pkg.sv
// Shared definitions for the melody buzzer: note codes, pitch table,
// ROM entry layout and sequencer states.
package buzzer_pkg;

    // ROM entry layout: {note[3:0], dur[1:0], 2'b00}
    localparam int ENTRY_W = 8;
    localparam int NOTE_W  = 4;
    localparam int DUR_W   = 2;

    localparam logic [NOTE_W-1:0] NOTA_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTA_DO4  = 4'd1;
    localparam logic [NOTE_W-1:0] NOTA_RE   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTA_MI   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTA_FA   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTA_SOL  = 4'd5;
    localparam logic [NOTE_W-1:0] NOTA_LA   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTA_SI   = 4'd7;
    localparam logic [NOTE_W-1:0] NOTA_DO5  = 4'd8;
    localparam logic [NOTE_W-1:0] NOTA_FIN  = 4'd15;

    // Frequencies in Hz for notes DO4..DO5 (codes 1..8)
    localparam int unsigned NOTE_FREQ [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_e;

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [NOTE_W-1:0] n,
                                                    input logic [DUR_W-1:0] d);
        return {n, d, 2'b00};
    endfunction

endpackage

// File: rtl/melodia_rom.sv
// Per-channel melody ROM with a registered (1-cycle) read.
module melodia_rom
    import buzzer_pkg::*;
#(
    parameter int CW = 2,
    parameter int IW = 4
) (
    input  logic               clk,
    input  logic [CW-1:0]      chan,
    input  logic [IW-1:0]      idx,
    output logic [ENTRY_W-1:0] entry
);

    // Melody table; any index past the listed notes reads as the end marker.
    function automatic logic [ENTRY_W-1:0] melody(input int c, input int i);
        melody = mk_entry(NOTA_FIN, 2'd0);
        case (c)
            0: case (i)
                0: melody = mk_entry(NOTA_MI, 2'd0);
                default: ;
            endcase
            1: case (i)
                0: melody = mk_entry(NOTA_REST, 2'd3);
                default: ;
            endcase
            2: case (i)
                0: melody = mk_entry(NOTA_DO4, 2'd0);
                1: melody = mk_entry(4'd12, 2'd0);  // unused code, plays as rest
                2: melody = mk_entry(NOTA_RE, 2'd0);
                3: melody = mk_entry(NOTA_MI, 2'd0);
                default: ;
            endcase
            3: case (i)
                0: melody = mk_entry(NOTA_LA, 2'd0);
                default: ;
            endcase
            default: case (i)
                0: melody = mk_entry(NOTA_DO5, 2'd0);
                default: ;
            endcase
        endcase
    endfunction

    // Registered read
    always_ff @(posedge clk) begin
        entry <= melody(int'(chan), int'(idx));
    end

endmodule

// File: rtl/buzzer_melodia.sv
// Multi-channel melody sequencer: edge-detected triggers with fixed
// priority pre-emption, note ROM playback, ms-based durations and a
// square-wave tone divider.
module buzzer_melodia
    import buzzer_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int N_CHAN    = 4,
    parameter int MAX_NOTES = 16,
    parameter int UNIT_MS   = 100,
    parameter int GAP_MS    = 20,
    localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
    localparam int IW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CHAN-1:0] trig,
    input  logic              mute,
    output logic              buzzer,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     chan_activo
);

    localparam int PRE = CLK_FREQ / 1000;
    localparam int PW  = $clog2(PRE + 1);
    localparam int MSW = $clog2(4 * UNIT_MS + GAP_MS + 1);
    localparam int TW  = $clog2(CLK_FREQ / (2 * NOTE_FREQ[0]) + 1);

    logic [N_CHAN-1:0]  trig_q, edg;
    logic               any_edge, preempt, restart;
    logic [CW-1:0]      sel, chan_q, rom_chan;
    logic [IW-1:0]      idx_q, rom_idx;
    logic [ENTRY_W-1:0] entry;
    logic [NOTE_W-1:0]  note;
    logic               pitched, pre_tick, gap_end, last_idx;
    logic [MSW-1:0]     note_ms;
    logic [TW-1:0]      hp;
    state_e             state_q;
    logic [PW-1:0]      pre_q;
    logic [MSW-1:0]     ms_q;
    logic [TW-1:0]      tcnt_q;
    logic               tone_q, busy_q, done_q;
    logic               unused_bits;

    // Half-period reload; every arm divides constants only
    function automatic logic [TW-1:0] hp_of(input logic [NOTE_W-1:0] n);
        hp_of = '0;
        for (int i = 0; i < 8; i++)
            if (n == NOTE_W'(i + 1)) hp_of = TW'(CLK_FREQ / (2 * NOTE_FREQ[i]) - 1);
    endfunction

    // Trigger history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trig_q <= '0;
        else        trig_q <= trig;
    end

    assign edg = trig & ~trig_q;

    // Lowest-index edge wins
    always_comb begin
        sel      = '0;
        any_edge = 1'b0;
        for (int c = N_CHAN - 1; c >= 0; c--) begin
            if (edg[c]) begin
                sel      = CW'(c);
                any_edge = 1'b1;
            end
        end
    end

    assign preempt = any_edge && (sel < chan_q) &&
                     (state_q == LOAD || state_q == PLAY || state_q == GAP);
    assign restart = (any_edge && state_q == IDLE) || preempt;

    assign note        = entry[ENTRY_W-1 -: NOTE_W];
    assign note_ms     = MSW'((int'(entry[3:2]) + 1) * UNIT_MS);
    assign pitched     = (note >= NOTA_DO4) && (note <= NOTA_DO5);
    assign hp          = hp_of(note);
    assign pre_tick    = (pre_q == PW'(PRE - 1));
    assign gap_end     = pre_tick && (ms_q == MSW'(GAP_MS - 1));
    assign last_idx    = (idx_q == IW'(MAX_NOTES - 1));
    assign unused_bits = ^entry[1:0];

    // ROM is addressed with the upcoming chan/idx so the entry is valid in LOAD
    always_comb begin
        rom_chan = chan_q;
        rom_idx  = idx_q;
        if (restart) begin
            rom_chan = sel;
            rom_idx  = '0;
        end else if (state_q == GAP && gap_end && !last_idx) begin
            rom_idx = idx_q + 1'b1;
        end
    end

    melodia_rom #(.CW(CW), .IW(IW)) u_rom (
        .clk   (clk),
        .chan  (rom_chan),
        .idx   (rom_idx),
        .entry (entry)
    );

    // Sequencer: note timing, tone generation and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= '0;
            idx_q   <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            tcnt_q  <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (restart) begin
                state_q <= LOAD;
                chan_q  <= sel;
                idx_q   <= '0;
                pre_q   <= '0;
                ms_q    <= '0;
                tcnt_q  <= '0;
                tone_q  <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: busy_q <= 1'b0;
                    LOAD: begin
                        if (note == NOTA_FIN) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= PLAY;
                            pre_q   <= '0;
                            ms_q    <= '0;
                            tcnt_q  <= '0;
                            tone_q  <= 1'b0;
                        end
                    end
                    PLAY: begin
                        if (pitched) begin
                            if (tcnt_q == hp) begin
                                tcnt_q <= '0;
                                tone_q <= ~tone_q;
                            end else begin
                                tcnt_q <= tcnt_q + 1'b1;
                            end
                        end
                        if (pre_tick) begin
                            pre_q <= '0;
                            if (ms_q == note_ms - 1'b1) begin
                                ms_q    <= '0;
                                state_q <= GAP;
                                tone_q  <= 1'b0;
                            end else begin
                                ms_q <= ms_q + 1'b1;
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                    GAP: begin
                        if (pre_tick) begin
                            pre_q <= '0;
                            if (gap_end) begin
                                ms_q <= '0;
                                if (last_idx) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    idx_q   <= idx_q + 1'b1;
                                    state_q <= LOAD;
                                end
                            end else begin
                                ms_q <= ms_q + 1'b1;
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign buzzer      = tone_q & ~mute;
    assign busy        = busy_q;
    assign done        = done_q;
    assign chan_activo = chan_q;

endmodule

// File: tb/tb_buzzer_melodia.sv
// Randomized bench for buzzer_melodia; a timeline model derived from the
// melody list predicts busy/done/buzzer/chan_activo every cycle.
module tb_buzzer_melodia;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int UNIT_MS   = 10;
    localparam int GAP_MS    = 2;
    localparam int MAX_NOTES = 16;
    localparam int CPMS      = CLK_FREQ / 1000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] trig  = '0;
    logic       mute  = 1'b0;
    logic       buzzer, busy, done;
    logic [1:0] chan_activo;

    buzzer_melodia #(
        .CLK_FREQ(CLK_FREQ), .N_CHAN(4), .MAX_NOTES(MAX_NOTES),
        .UNIT_MS(UNIT_MS), .GAP_MS(GAP_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .mute(mute),
        .buzzer(buzzer), .busy(busy), .done(done), .chan_activo(chan_activo)
    );

    always #5 clk = ~clk;

    int    checks = 0, failures = 0, done_cnt = 0;
    string scen = "reset";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Melodies as notes/durations; entries past index 4 are end markers
    int mel_n [4][5] = '{'{3, 15, 15, 15, 15}, '{0, 15, 15, 15, 15},
                         '{1, 12, 2, 3, 15},   '{6, 15, 15, 15, 15}};
    int mel_d [4][5] = '{'{0, 0, 0, 0, 0}, '{3, 0, 0, 0, 0},
                         '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
    int freq  [9]    = '{0, 262, 294, 330, 349, 392, 440, 494, 523};

    // k cycles after the accepted edge: 0 idle, 1 load/play/gap, 2 done pulse
    function automatic int phase(input int c, input int k, output bit tn);
        int t, n, d, len;
        t  = k;
        tn = 1'b0;
        for (int i = 0; i < MAX_NOTES; i++) begin
            n = 15; d = 0;
            if (i < 5) begin n = mel_n[c][i]; d = mel_d[c][i]; end
            if (t == 0) return 1;
            t--;
            if (n == 15) return (t == 0) ? 2 : 0;
            len = (d + 1) * UNIT_MS * CPMS;
            if (t < len) begin
                if (n >= 1 && n <= 8) tn = ((t / (CLK_FREQ / (2 * freq[n]))) % 2) == 1;
                return 1;
            end
            t -= len;
            if (t < GAP_MS * CPMS) return 1;
            t -= GAP_MS * CPMS;
        end
        return (t == 0) ? 2 : 0;
    endfunction

    int         cyc = 0, m_start = 0, m_chan = 0;
    bit         m_act = 1'b0;
    logic [3:0] prev = '0;

    function automatic int lowest(input logic [3:0] e);
        for (int i = 0; i < 4; i++) if (e[i]) return i;
        return 0;
    endfunction

    function automatic bit accept(input logic [3:0] e);
        bit tn;
        int ph;
        if (e == '0) return 1'b0;
        ph = m_act ? phase(m_chan, cyc - m_start, tn) : 0;
        return (ph == 0) || (ph == 1 && lowest(e) < m_chan);
    endfunction

    function automatic logic [4:0] expect_out();
        bit tn;
        int ph;
        tn = 1'b0;
        ph = m_act ? phase(m_chan, cyc - m_start, tn) : 0;
        return {ph != 0, ph == 2, tn & ~mute, 2'(m_chan)};
    endfunction

    // Reference model of trigger acceptance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_chan <= 0;
            prev   <= '0;
        end else begin
            cyc  <= cyc + 1;
            prev <= trig;
            if (accept(trig & ~prev)) begin
                m_act   <= 1'b1;
                m_chan  <= lowest(trig & ~prev);
                m_start <= cyc + 1;
            end
        end
    end

    // Per-cycle output comparison, away from the active edge
    always @(negedge clk) begin
        chk(scen, 32'({busy, done, buzzer, chan_activo}), 32'(expect_out()));
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        trig = v;
        step(1);
        trig = '0;
    endtask

    task automatic wait_idle();
        int n;
        logic [4:0] e;
        n = 0;
        e = expect_out();
        while (e[4] && n < 60000) begin
            step(1);
            n++;
            e = expect_out();
        end
    endtask

    initial begin
        int base;
        // reset with trig activity
        scen = "reset";
        repeat (20) begin
            trig = 4'($urandom);
            step(1);
        end
        trig = '0;
        step(2);
        rst_n = 1'b1;
        step(50 + $urandom_range(0, 50));
        chk("reset_busy", 32'(busy), 32'd0);

        // single LA note, held trigger, same-channel retrigger, mute window
        scen = "ch3_note";
        base = done_cnt;
        trig = 4'b1000;
        step($urandom_range(1, 4));
        trig = '0;
        step($urandom_range(100, 2000));
        pulse(4'b1000);
        step($urandom_range(500, 3000));
        mute = 1'b1;
        step($urandom_range(500, 3000));
        mute = 1'b0;
        wait_idle();
        step(2);
        chk("ch3_done_cnt", 32'(done_cnt - base), 32'd1);

        // simultaneous edges, long rest, dropped lower-priority edges
        scen = "simul_rest";
        base = done_cnt;
        pulse(4'b0110);
        chk("simul_chan", 32'(chan_activo), 32'd1);
        repeat (5) begin
            step($urandom_range(2000, 6000));
            pulse(4'($urandom_range(1, 7) << 1));
        end
        wait_idle();
        step(2);
        chk("rest_done_cnt", 32'(done_cnt - base), 32'd1);

        // channel 2 pre-empted by channel 0 (sometimes while still in LOAD)
        scen = "preempt";
        base = done_cnt;
        pulse(4'b0100);
        step(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1000, 12000));
        pulse(4'b0001 | (4'($urandom_range(0, 15)) & 4'b1110));
        chk("pre_buzzer", 32'(buzzer), 32'd0);
        chk("pre_chan", 32'(chan_activo), 32'd0);
        chk("pre_busy", 32'(busy), 32'd1);
        wait_idle();
        step(2);
        chk("pre_done_cnt", 32'(done_cnt - base), 32'd1);

        // reset mid-melody aborts without a done pulse
        scen = "abort";
        base = done_cnt;
        pulse(4'b0100);
        step($urandom_range(100, 3000));
        rst_n = 1'b0;
        step(3);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_buzzer", 32'(buzzer), 32'd0);
        rst_n = 1'b1;
        step(20);
        chk("abort_done_cnt", 32'(done_cnt - base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
